// File: rtl/mem_port_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_pkg
// Shared widths and the request record used by the memory-port ingress
// buffer and its per-port FIFOs.
//   TAG_W      client tag width
//   ADDR_W     request address width (bank select + row)
//   DATA_W     write-data width
//   BANK_SEL_W bank-select bits at the top of the address
//   mem_req_t  {tag, addr, data, wen}, 31 bits at the default widths
// ---------------------------------------------------------------------------
package mem_port_pkg;

  localparam int TAG_W      = 2;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int BANK_SEL_W = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
  } mem_req_t;

endpackage

// File: rtl/req_fifo.sv
// ---------------------------------------------------------------------------
// req_fifo
// DEPTH-entry FIFO of mem_req_t. Occupancy is tracked in an explicit level
// counter, so full/empty never depend on pointer equality.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push, wr_req write wr_req at the tail (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   head         entry at the head, read straight from storage
//   level        occupancy, 0..DEPTH
//   full, empty  decoded from level
// ---------------------------------------------------------------------------
module req_fifo
  import mem_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  mem_req_t         wr_req,
  output mem_req_t         head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  mem_req_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because level gates their use.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_req;
    end
  end

endmodule

// File: rtl/mem_port_ingress_buffer.sv
// ---------------------------------------------------------------------------
// mem_port_ingress_buffer
// Upstream stage of the 4-bank memory cluster. Queues requests from three
// client ports in per-port FIFOs and presents each port's head entry to the
// cluster. While freeze_inputs is high nothing is popped, so requests the
// cluster masks during freeze are held here rather than lost.
// Ports (N = 1..3):
//   clk, reset                   rising-edge clock, sync active-high reset
//   portN_req_valid/ready        client handshake; ready = level < DEPTH
//   portN_req_tag/addr/data/wen  client request fields
//   freeze_inputs                cluster consumes nothing this cycle
//   portN_req_tag_out/addr/data_in/wen/valid  head entry to the cluster,
//                                all zero when the port queue is empty
//   portN_level                  current occupancy
// Optional build macro MEM_INGRESS_BYPASS_EN: when a port is empty and not
// frozen, a valid client request is passed straight to the cluster in the
// same cycle and never written into the FIFO.
// ---------------------------------------------------------------------------
module mem_port_ingress_buffer
  import mem_port_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze_inputs,
  input  logic              port1_req_valid,
  output logic              port1_req_ready,
  input  logic [TAG_W-1:0]  port1_req_tag,
  input  logic [ADDR_W-1:0] port1_req_addr,
  input  logic [DATA_W-1:0] port1_req_data,
  input  logic              port1_req_wen,
  output logic [TAG_W-1:0]  port1_req_tag_out,
  output logic [ADDR_W-1:0] port1_addr,
  output logic [DATA_W-1:0] port1_data_in,
  output logic              port1_wen,
  output logic              port1_valid,
  output logic [LVL_W-1:0]  port1_level,
  input  logic              port2_req_valid,
  output logic              port2_req_ready,
  input  logic [TAG_W-1:0]  port2_req_tag,
  input  logic [ADDR_W-1:0] port2_req_addr,
  input  logic [DATA_W-1:0] port2_req_data,
  input  logic              port2_req_wen,
  output logic [TAG_W-1:0]  port2_req_tag_out,
  output logic [ADDR_W-1:0] port2_addr,
  output logic [DATA_W-1:0] port2_data_in,
  output logic              port2_wen,
  output logic              port2_valid,
  output logic [LVL_W-1:0]  port2_level,
  input  logic              port3_req_valid,
  output logic              port3_req_ready,
  input  logic [TAG_W-1:0]  port3_req_tag,
  input  logic [ADDR_W-1:0] port3_req_addr,
  input  logic [DATA_W-1:0] port3_req_data,
  input  logic              port3_req_wen,
  output logic [TAG_W-1:0]  port3_req_tag_out,
  output logic [ADDR_W-1:0] port3_addr,
  output logic [DATA_W-1:0] port3_data_in,
  output logic              port3_wen,
  output logic              port3_valid,
  output logic [LVL_W-1:0]  port3_level
);

  logic             in_valid_s  [3];
  mem_req_t         in_req_s    [3];
  mem_req_t         out_req_s   [3];
  logic             out_valid_s [3];
  logic             ready_s     [3];
  logic [LVL_W-1:0] level_s     [3];

  assign in_valid_s[0] = port1_req_valid;
  assign in_valid_s[1] = port2_req_valid;
  assign in_valid_s[2] = port3_req_valid;
  assign in_req_s[0]   = {port1_req_tag, port1_req_addr, port1_req_data, port1_req_wen};
  assign in_req_s[1]   = {port2_req_tag, port2_req_addr, port2_req_data, port2_req_wen};
  assign in_req_s[2]   = {port3_req_tag, port3_req_addr, port3_req_data, port3_req_wen};

  for (genvar p = 0; p < 3; p++) begin : g_port
    mem_req_t         head_s;
    mem_req_t         out_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic             full_s;
    logic             empty_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push_s),
      .pop    (pop_s),
      .wr_req (in_req_s[p]),
      .head   (head_s),
      .level  (fifo_level_s),
      .full   (full_s),
      .empty  (empty_s)
    );

    // Output select, freeze gating and optional same-cycle bypass.
    always_comb begin
      bypass_s = 1'b0;
      out_s    = '0;
      valid_s  = 1'b0;
`ifdef MEM_INGRESS_BYPASS_EN
      bypass_s = empty_s && !freeze_inputs && in_valid_s[p];
`endif
      if (bypass_s) begin
        out_s   = in_req_s[p];
        valid_s = 1'b1;
      end else if (!empty_s) begin
        out_s   = head_s;
        valid_s = 1'b1;
      end else begin
        out_s   = '0;
        valid_s = 1'b0;
      end
      // A bypassed request is consumed by the cluster directly, never stored.
      push_s = in_valid_s[p] && !full_s && !bypass_s;
      pop_s  = !empty_s && !freeze_inputs;
    end

    assign out_req_s[p]   = out_s;
    assign out_valid_s[p] = valid_s;
    assign ready_s[p]     = !full_s;
    assign level_s[p]     = fifo_level_s;
  end

  assign port1_req_ready   = ready_s[0];
  assign port1_req_tag_out = out_req_s[0].tag;
  assign port1_addr        = out_req_s[0].addr;
  assign port1_data_in     = out_req_s[0].data;
  assign port1_wen         = out_req_s[0].wen;
  assign port1_valid       = out_valid_s[0];
  assign port1_level       = level_s[0];

  assign port2_req_ready   = ready_s[1];
  assign port2_req_tag_out = out_req_s[1].tag;
  assign port2_addr        = out_req_s[1].addr;
  assign port2_data_in     = out_req_s[1].data;
  assign port2_wen         = out_req_s[1].wen;
  assign port2_valid       = out_valid_s[1];
  assign port2_level       = level_s[1];

  assign port3_req_ready   = ready_s[2];
  assign port3_req_tag_out = out_req_s[2].tag;
  assign port3_addr        = out_req_s[2].addr;
  assign port3_data_in     = out_req_s[2].data;
  assign port3_wen         = out_req_s[2].wen;
  assign port3_valid       = out_valid_s[2];
  assign port3_level       = level_s[2];

endmodule
